fp_sqrt_iter: RTL

Iterative square-root datapath for a positive finite operand. Normalises subnormals, halves the exponent, and computes the rooted significand one bit per cycle with a restoring digit recurrence. Emits the unrounded sign, exponent, significand and round/sticky bits. It sits directly upstream of the fp_sqrt special-case/packing stage, which feeds these bits to the rounding stage.

---
 rtl/fp_pkg.sv | 49 ++++
 rtl/fp_sqrt_iter_if.sv | 30 +++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_sqrt_iter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point formats, sqrt FSM states and result record
// Ports: none (package). Provides fp_format_e, exp_bits/man_bits, GUARD_BITS,
//        sqrt_state_e and sqrt_iter_res_t.
package fp_pkg;

   typedef enum logic [1:0] {
      FP16 = 2'd0,
      FP32 = 2'd1,
      FP64 = 2'd2
   } fp_format_e;

   // Root bits kept beyond the stored fraction: the hidden bit and the round bit.
   localparam int GUARD_BITS = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } sqrt_state_e;

   // Sized for the widest format so one record type serves every instance.
   localparam int RES_EXP_W  = 11;
   localparam int RES_MANT_W = 53;

   typedef struct packed {
      logic                  sign;
      logic [RES_EXP_W-1:0]  exp;
      logic [RES_MANT_W-1:0] mant;
      logic [1:0]            rs;
   } sqrt_iter_res_t;

   function automatic int exp_bits(input fp_format_e f);
      case (f)
         FP16:    return 5;
         FP64:    return 11;
         default: return 8;
      endcase
   endfunction

   function automatic int man_bits(input fp_format_e f);
      case (f)
         FP16:    return 10;
         FP64:    return 52;
         default: return 23;
      endcase
   endfunction

endpackage

// File: rtl/fp_sqrt_iter_if.sv
// rtl/fp_sqrt_iter_if.sv - start/operand/result bundle of the iterative square root
// Ports (signals): start_i, a_i (requester to datapath); busy_o, done_o, sign_o,
//                  exp_o, mant_o, rs_o (datapath to requester).
// Modports: master (requester side), slave (fp_sqrt_iter side).
interface fp_sqrt_iter_if import fp_pkg::*; #(
   parameter fp_format_e FP_FORMAT = FP32
);
   localparam int EXP_WIDTH  = exp_bits(FP_FORMAT);
   localparam int MANT_WIDTH = man_bits(FP_FORMAT);
   localparam int FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH;

   logic                  start_i;
   logic [FP_WIDTH-1:0]   a_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  sign_o;
   logic [EXP_WIDTH-1:0]  exp_o;
   logic [MANT_WIDTH:0]   mant_o;
   logic [1:0]            rs_o;

   modport master (
      output start_i, a_i,
      input  busy_o, done_o, sign_o, exp_o, mant_o, rs_o
   );

   modport slave (
      input  start_i, a_i,
      output busy_o, done_o, sign_o, exp_o, mant_o, rs_o
   );
endinterface

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
// Ports: in_bits (WIDTH) vector to scan; lz (CNT_W) number of leading zeros,
//        equal to WIDTH when in_bits is all zero.
module fp_lzc #(
   parameter int WIDTH = 24,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] in_bits,
   output logic [CNT_W-1:0] lz
);
   // Ascending scan: the last hit is the most significant set bit.
   always_comb begin
      lz = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (in_bits[i]) lz = CNT_W'(WIDTH - 1 - i);
      end
   end
endmodule

// File: rtl/fp_sqrt_iter.sv
// rtl/fp_sqrt_iter.sv - iterative restoring square root of a positive finite operand
// Ports: clk_i clock; reset_i asynchronous active-low reset;
//        io (fp_sqrt_iter_if.slave): start_i/a_i request, busy_o/done_o status,
//        sign_o/exp_o/mant_o/rs_o unrounded result held between done_o pulses.
// Macro: FP_SQRT_RADIX4_EN retires two root bits per ITER cycle.
module fp_sqrt_iter import fp_pkg::*; #(
   parameter fp_format_e FP_FORMAT = FP32
) (
   input  logic           clk_i,
   input  logic           reset_i,
   fp_sqrt_iter_if.slave  io
);
   localparam int EXP_WIDTH  = exp_bits(FP_FORMAT);
   localparam int MANT_WIDTH = man_bits(FP_FORMAT);
   localparam int FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH;
   localparam int BIAS       = 2**(EXP_WIDTH-1) - 1;
   localparam int N          = MANT_WIDTH + GUARD_BITS;
`ifdef FP_SQRT_RADIX4_EN
   localparam int ITERS      = (N + 1) / 2;
   localparam int RW         = 2 * ITERS;
`else
   localparam int ITERS      = N;
   localparam int RW         = N;
`endif
   // Root bits computed beyond N; nonzero only when radix-4 runs an odd N.
   localparam int PAD        = RW - N;
   localparam int E_W        = EXP_WIDTH + 2;
   localparam int CNT_W      = $clog2(ITERS + 1);
   localparam int LZ_W       = $clog2(MANT_WIDTH + 2);

   typedef struct packed {
      logic [RW+1:0]   rem;
      logic [RW-1:0]   root;
      logic [2*RW-1:0] rad;
   } iter_t;

   // One restoring digit: bring down a radicand pair, try subtracting {root,01}.
   function automatic iter_t sqrt_step(input iter_t s);
      iter_t         o;
      logic [RW+3:0] sh;
      logic [RW+3:0] cmp;
      logic          ge;
      sh     = {s.rem, s.rad[2*RW-1 -: 2]};
      cmp    = {2'b00, s.root, 2'b01};
      ge     = (sh >= cmp);
      o.rem  = ge ? (RW+2)'(sh - cmp) : sh[RW+1:0];
      o.root = {s.root[RW-2:0], ge};
      o.rad  = {s.rad[2*RW-3:0], 2'b00};
      return o;
   endfunction

   sqrt_state_e           state_q, state_d;
   logic [FP_WIDTH-1:0]   a_q;
   iter_t                 it_q, nxt;
   logic [CNT_W-1:0]      cnt_q;
   logic [EXP_WIDTH-1:0]  exp_hold_q;
   logic                  sign_q;
   logic [EXP_WIDTH-1:0]  exp_q;
   logic [MANT_WIDTH:0]   mant_q;
   logic [1:0]            rs_q;

   logic [EXP_WIDTH-1:0]  a_exp;
   logic [MANT_WIDTH-1:0] a_man;
   logic [LZ_W-1:0]       lz;
   logic                  is_sub, is_zero, accept, sticky;
   logic [MANT_WIDTH:0]   sig_m;
   logic [N-1:0]          sig_n;
   logic signed [E_W-1:0] e_unb, e_even;
   logic [EXP_WIDTH-1:0]  exp_n;

   assign a_exp  = a_q[FP_WIDTH-2 -: EXP_WIDTH];
   assign a_man  = a_q[MANT_WIDTH-1:0];
   assign accept = io.start_i && ((state_q == IDLE) || (state_q == DONE));

   fp_lzc #(.WIDTH(MANT_WIDTH + 1), .CNT_W(LZ_W)) u_lzc (
      .in_bits ({1'b0, a_man}),
      .lz      (lz)
   );

   // Normalise, then make the exponent even so it halves exactly; the odd
   // case moves one factor of two into the significand instead.
   always_comb begin
      is_sub  = (a_exp == '0);
      is_zero = is_sub && (a_man == '0);
      if (is_sub) begin
         sig_m = {1'b0, a_man} << lz;
         e_unb = E_W'(1) - E_W'(BIAS) - E_W'(lz);
      end else begin
         sig_m = {1'b1, a_man};
         e_unb = E_W'(a_exp) - E_W'(BIAS);
      end
      if (e_unb[0]) begin
         sig_n  = {sig_m, 1'b0};
         e_even = e_unb - E_W'(1);
      end else begin
         sig_n  = {1'b0, sig_m};
         e_even = e_unb;
      end
      exp_n = is_zero ? '0 : EXP_WIDTH'(($signed(e_even) >>> 1) + E_W'(BIAS));
   end

`ifdef FP_SQRT_RADIX4_EN
   assign nxt = sqrt_step(sqrt_step(it_q));
`else
   assign nxt = sqrt_step(it_q);
`endif

   // With a padding root bit, that bit only ever contributes to sticky.
   assign sticky = (|nxt.rem) | ((PAD != 0) & nxt.root[0]);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (io.start_i) state_d = NORM;
         NORM:    state_d = ITER;
         ITER:    if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = io.start_i ? NORM : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         a_q        <= '0;
         it_q       <= '0;
         cnt_q      <= '0;
         exp_hold_q <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         mant_q     <= '0;
         rs_q       <= 2'b00;
      end else begin
         if (accept) a_q <= io.a_i;
         case (state_q)
            NORM: begin
               it_q       <= '{rem: '0, root: '0, rad: {sig_n, {(2*RW-N){1'b0}}}};
               cnt_q      <= CNT_W'(ITERS - 1);
               exp_hold_q <= exp_n;
            end
            ITER: begin
               it_q <= nxt;
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  // Result registers load only on the step that enters DONE.
                  sign_q <= a_q[FP_WIDTH-1];
                  exp_q  <= exp_hold_q;
                  mant_q <= nxt.root[RW-1 -: MANT_WIDTH+1];
                  rs_q   <= {nxt.root[PAD], sticky};
               end
            end
            default: ;
         endcase
      end
   end

   assign io.busy_o = (state_q == NORM) || (state_q == ITER);
   assign io.done_o = (state_q == DONE);
   assign io.sign_o = sign_q;
   assign io.exp_o  = exp_q;
   assign io.mant_o = mant_q;
   assign io.rs_o   = rs_q;
endmodule
